// File: rtl/adpll_lock_sequencer.sv
// adpll_lock_sequencer: brings the ADPLL from reset to lock and supervises lock afterwards
module adpll_lock_sequencer #(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int LOCK_TOL       = 2,
    parameter int LOCK_COUNT     = 16,
    parameter int UNLOCK_TOL     = 8,
    parameter int UNLOCK_COUNT   = 4,
    parameter int ACQ_TIMEOUT    = 4096,
    parameter int RESTART_CYCLES = 256,
    parameter int MAX_RESTARTS   = 7
) (
    input  logic       fpga_clk_i,
    input  logic       reset_i,
    input  logic       ref_clk_i,
    input  logic       run_i,
    input  logic       phase_step_i,
    input  logic [7:0] error_i,
    output logic       adpll_en_o,
    output logic [1:0] ref_sel_o,
    output logic       locked_o,
    output logic       fault_o,
    output logic [2:0] state_o,
    output logic [2:0] restart_cnt_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        ACQUIRE = 3'd2,
        LOCKED  = 3'd3,
        RESTART = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam int CYC_MAX = (SETTLE_CYCLES > RESTART_CYCLES) ? SETTLE_CYCLES : RESTART_CYCLES;
    localparam int CW = $clog2(CYC_MAX + 1);
    localparam int TW = $clog2(ACQ_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);

    state_t state, state_d;
    logic [2:0] ref_sync;
    logic tick, sample;
    logic [7:0] err;
    logic [8:0] mag;
    logic [CW-1:0] cyc;
    logic [TW-1:0] timeout;
    logic [LW-1:0] lock_run;
    logic [UW-1:0] unlock_run;
    logic in_lock, out_lock, lock_hit, timeout_hit, unlock_hit, step_hit, entering;

    // 9-bit magnitude so that -128 maps to 128 rather than wrapping
    assign mag         = err[7] ? 9'd0 - {1'b1, err} : {1'b0, err};
    assign in_lock     = mag <= 9'(LOCK_TOL);
    assign out_lock    = mag > 9'(UNLOCK_TOL);
    assign lock_hit    = sample && in_lock && lock_run == LW'(LOCK_COUNT - 1);
    assign timeout_hit = sample && timeout == TW'(ACQ_TIMEOUT - 1);
    assign unlock_hit  = sample && out_lock && unlock_run == UW'(UNLOCK_COUNT - 1);
    assign step_hit    = run_i && phase_step_i && state == LOCKED;
    assign entering    = state_d != state;
    assign state_o     = state;

    // synchronise the reference clock, form a one-cycle tick and capture the error on it
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            ref_sync <= '0;
            tick     <= 1'b0;
            sample   <= 1'b0;
            err      <= '0;
        end else begin
            ref_sync <= {ref_sync[1:0], ref_clk_i};
            tick     <= ref_sync[1] & ~ref_sync[2];
            sample   <= tick;
            if (tick) err <= error_i;
        end
    end

    // next-state selection; lock beats timeout, and a phase step shares the unlock exit
    always_comb begin
        state_d = state;
        if (!run_i) state_d = IDLE;
        else if (state == IDLE) state_d = SETTLE;
        else if (state == SETTLE && cyc == CW'(SETTLE_CYCLES - 1)) state_d = ACQUIRE;
        else if (state == ACQUIRE && lock_hit) state_d = LOCKED;
        else if (state == ACQUIRE && timeout_hit) state_d = (restart_cnt_o == 3'(MAX_RESTARTS)) ? FAULT : RESTART;
        else if (state == LOCKED && (step_hit || unlock_hit)) state_d = ACQUIRE;
        else if (state == RESTART && cyc == CW'(RESTART_CYCLES - 1)) state_d = SETTLE;
    end

    // state register, run/timeout counters and registered outputs decoded from the next state
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            cyc           <= '0;
            timeout       <= '0;
            lock_run      <= '0;
            unlock_run    <= '0;
            ref_sel_o     <= '0;
            restart_cnt_o <= '0;
            adpll_en_o    <= 1'b0;
            locked_o      <= 1'b0;
            fault_o       <= 1'b0;
        end else begin
            state <= state_d;
            cyc   <= entering ? '0 : cyc + 1'b1;
            if (entering) begin
                timeout    <= '0;
                lock_run   <= '0;
                unlock_run <= '0;
            end else if (sample && state == ACQUIRE) begin
                timeout  <= timeout + 1'b1;
                lock_run <= in_lock ? lock_run + 1'b1 : '0;
            end else if (sample && state == LOCKED) begin
                unlock_run <= out_lock ? unlock_run + 1'b1 : '0;
            end
            if (step_hit) ref_sel_o <= ref_sel_o + 1'b1;
            if (state == IDLE && state_d == SETTLE) restart_cnt_o <= '0;
            else if (entering && state_d == RESTART && restart_cnt_o != 3'(MAX_RESTARTS)) restart_cnt_o <= restart_cnt_o + 1'b1;
            adpll_en_o <= state_d inside {SETTLE, ACQUIRE, LOCKED};
            locked_o   <= state_d == LOCKED;
            fault_o    <= state_d == FAULT;
        end
    end
endmodule

// File: tb/tb_adpll_lock_sequencer.sv
// tb_adpll_lock_sequencer: scoreboard bench; each state transition is popped and checked with its dwell
`timescale 1ns/1ps
module tb_adpll_lock_sequencer;
    localparam int P    = 50;
    localparam int W4L  = 4 * P - P / 2;
    localparam int W4H  = 4 * P + P / 2;
    localparam int W16L = 16 * P - P / 2;
    localparam int W16H = 16 * P + P / 2;

    typedef struct {
        logic [10:0] v;
        int dmin;
        int dmax;
    } exp_t;

    logic fpga_clk_i, reset_i, ref_clk_i, run_i, phase_step_i;
    logic [7:0] error_i;
    logic adpll_en_o, locked_o, fault_o;
    logic [1:0] ref_sel_o;
    logic [2:0] state_o, restart_cnt_o;
    logic [10:0] outs;
    exp_t q[$];
    exp_t em;
    logic [2:0] prev_state;
    int cyc;
    int checks = 0;
    int errors = 0;

    assign outs = {state_o, locked_o, fault_o, adpll_en_o, ref_sel_o, restart_cnt_o};

    adpll_lock_sequencer #(
        .SETTLE_CYCLES(8), .LOCK_TOL(2), .LOCK_COUNT(4), .UNLOCK_TOL(8), .UNLOCK_COUNT(2),
        .ACQ_TIMEOUT(16), .RESTART_CYCLES(8), .MAX_RESTARTS(2)
    ) dut (
        .fpga_clk_i(fpga_clk_i), .reset_i(reset_i), .ref_clk_i(ref_clk_i), .run_i(run_i),
        .phase_step_i(phase_step_i), .error_i(error_i), .adpll_en_o(adpll_en_o),
        .ref_sel_o(ref_sel_o), .locked_o(locked_o), .fault_o(fault_o), .state_o(state_o),
        .restart_cnt_o(restart_cnt_o)
    );

    initial begin
        fpga_clk_i = 1'b0;
        forever #2 fpga_clk_i = ~fpga_clk_i;
    end

    initial begin
        ref_clk_i = 1'b0;
        #1;
        forever #100 ref_clk_i = ~ref_clk_i;
    end

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got {st,lk,ft,en,rs,rc}=%h want %h", name, got, want);
        end
    endtask

    task automatic push(input int st, input int lk, input int ft, input int en, input int rs, input int rc, input int dmin, input int dmax);
        exp_t e;
        e.v    = {3'(st), 1'(lk), 1'(ft), 1'(en), 2'(rs), 3'(rc)};
        e.dmin = dmin;
        e.dmax = dmax;
        q.push_back(e);
    endtask

    task automatic wait_q(input int n, input int budget);
        int k = 0;
        while (q.size() > n && k < budget) begin
            @(negedge fpga_clk_i);
            k++;
        end
        if (q.size() > n) begin
            checks++;
            errors++;
            $display("FAIL wait_q pending=%0d want<=%0d", q.size(), n);
            q.delete();
        end
    endtask

    task automatic align();
        @(posedge ref_clk_i);
        repeat (10) @(negedge fpga_clk_i);
    endtask

    task automatic pulse_step();
        phase_step_i = 1'b1;
        @(negedge fpga_clk_i);
        phase_step_i = 1'b0;
    endtask

    // monitor: every state change must match the oldest expected record and its dwell window
    initial begin
        prev_state = 3'd0;
        cyc = 0;
        forever begin
            @(negedge fpga_clk_i);
            cyc++;
            if (state_o !== prev_state) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transition got state=%0d want none (from %0d)", state_o, prev_state);
                end else begin
                    em = q.pop_front();
                    check("transition", outs, em.v);
                    if (em.dmax > 0) begin
                        checks++;
                        if (cyc < em.dmin || cyc > em.dmax) begin
                            errors++;
                            $display("FAIL dwell into state %0d got %0d cycles want %0d..%0d", state_o, cyc, em.dmin, em.dmax);
                        end
                    end
                end
                prev_state = state_o;
                cyc = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        run_i = 1'b0;
        phase_step_i = 1'b0;
        error_i = 8'd0;
        repeat (3) @(posedge fpga_clk_i);
        #1 check("reset", outs, 11'd0);
        @(negedge fpga_clk_i) reset_i = 1'b0;

        // lock from IDLE
        push(1, 0, 0, 1, 0, 0, 0, 0);
        push(2, 0, 0, 1, 0, 0, 8, 8);
        push(3, 1, 0, 1, 0, 0, W4L, W4H);
        align();
        run_i = 1'b1;
        wait_q(0, 400);

        // hysteresis band holds lock, then two samples beyond UNLOCK_TOL drop it
        error_i = 8'd5;
        repeat (10) @(posedge ref_clk_i);
        repeat (10) @(negedge fpga_clk_i);
        check("band_hold", outs, {3'd3, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0});
        push(2, 0, 0, 1, 0, 0, 0, 0);
        error_i = 8'(-9);
        wait_q(0, 400);
        push(3, 1, 0, 1, 0, 0, W4L, W4H);
        error_i = 8'd0;
        wait_q(0, 400);

        // five phase steps with relock in between; the extra pulse in ACQUIRE is ignored
        for (int i = 1; i <= 5; i++) begin
            push(2, 0, 0, 1, i % 4, 0, 0, 0);
            push(3, 1, 0, 1, i % 4, 0, W4L, W4H);
            align();
            pulse_step();
            if (i == 5) begin
                wait_q(1, 400);
                pulse_step();
            end
            wait_q(0, 400);
        end

        // -128 must read as out of lock
        push(2, 0, 0, 1, 1, 0, 0, 0);
        align();
        error_i = 8'h80;
        wait_q(0, 400);
        push(3, 1, 0, 1, 1, 0, W4L, W4H);
        error_i = 8'd0;
        wait_q(0, 400);

        // phase step lands on the cycle the second bad sample is evaluated
        push(2, 0, 0, 1, 2, 0, 0, 0);
        align();
        error_i = 8'(-9);
        @(posedge ref_clk_i);
        @(posedge ref_clk_i);
        repeat (4) @(posedge fpga_clk_i);
        @(negedge fpga_clk_i);
        pulse_step();
        wait_q(0, 400);
        push(3, 1, 0, 1, 2, 0, W4L, W4H);
        error_i = 8'd0;
        wait_q(0, 400);

        // asynchronous reset while locked clears outputs before the next clock edge
        push(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge fpga_clk_i);
        #0.5 reset_i = 1'b1;
        run_i = 1'b0;
        #0.5 check("async_reset", outs, 11'd0);
        @(negedge fpga_clk_i) reset_i = 1'b0;
        wait_q(0, 50);

        // acquisition timeouts: two restarts then FAULT, cleared by run_i=0
        push(1, 0, 0, 1, 0, 0, 0, 0);
        push(2, 0, 0, 1, 0, 0, 8, 8);
        push(4, 0, 0, 0, 0, 1, W16L, W16H);
        push(1, 0, 0, 1, 0, 1, 8, 8);
        push(2, 0, 0, 1, 0, 1, 8, 8);
        push(4, 0, 0, 0, 0, 2, W16L, W16H);
        push(1, 0, 0, 1, 0, 2, 8, 8);
        push(2, 0, 0, 1, 0, 2, 8, 8);
        push(5, 0, 1, 0, 0, 2, W16L, W16H);
        align();
        error_i = 8'd20;
        run_i = 1'b1;
        wait_q(0, 4000);
        repeat (3) @(posedge ref_clk_i);
        @(negedge fpga_clk_i);
        check("fault_sticky", outs, {3'd5, 1'b0, 1'b1, 1'b0, 2'd0, 3'd2});
        push(0, 0, 0, 0, 0, 2, 0, 0);
        run_i = 1'b0;
        wait_q(0, 50);

        repeat (20) @(negedge fpga_clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
